// File: rtl/div_pkg.sv
// Shared widths, FSM state type and saturation constants for the 256/128 signed divider.
package div_pkg;

    localparam int DIVIDEND_W = 256;
    localparam int DIVISOR_W  = 128;
    localparam int QUOT_W     = 128;
    localparam int ITER_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [QUOT_W-1:0] QUOT_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0] QUOT_MIN = {1'b1, {(QUOT_W-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial subtract, restore-select.
// Purely combinational; no backpressure.
module div_step
    import div_pkg::*;
(
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] trial;

    assign shifted = {rem_in, bit_in};
    assign trial   = shifted - {2'b00, divisor};

    // A non-negative trial result means the divisor fits: keep the difference.
    assign q_bit   = ~trial[DIVISOR_W+1];
    assign rem_out = q_bit ? trial[DIVISOR_W:0] : shifted[DIVISOR_W:0];

endmodule

// File: rtl/seq_divider_256.sv
// Sequential signed 256/128 divider; done 257 cycles after start (2 for a zero divisor).
// No backpressure: start is ignored while busy, results held until the next completion.
module seq_divider_256
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [QUOT_W-1:0]     quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam logic [DIVIDEND_W-1:0] NEG_LIMIT =
        {{(DIVIDEND_W-QUOT_W){1'b0}}, 1'b1, {(QUOT_W-1){1'b0}}};

    state_t                  state;
    logic [ITER_CNT_W-1:0]   cnt;
    logic [DIVIDEND_W-1:0]   dvd_q;
    logic [DIVISOR_W:0]      rem;
    logic [DIVISOR_W-1:0]    dvs;
    logic                    sign_dvd;
    logic                    sign_dvs;
    logic                    zero_div;
    logic                    fin_wait;

    logic [DIVIDEND_W-1:0]   dividend_abs;
    logic [DIVISOR_W-1:0]    divisor_abs;
    logic [DIVISOR_W:0]      rem_next;
    logic                    q_bit;
    logic                    neg_q;
    logic                    q_ovf;
    logic [QUOT_W-1:0]       q_lo;
    logic [QUOT_W-1:0]       q_signed;
    logic [QUOT_W-1:0]       q_sat;
    logic [DIVISOR_W-1:0]    r_signed;

    assign dividend_abs = dividend[DIVIDEND_W-1] ? -dividend : dividend;
    assign divisor_abs  = divisor[DIVISOR_W-1]   ? -divisor  : divisor;

    div_step u_step (
        .rem_in  (rem),
        .bit_in  (dvd_q[DIVIDEND_W-1]),
        .divisor (dvs),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    // Quotient bits enter at the LSB as dividend bits leave the MSB, so dvd_q ends as |quotient|.
    assign neg_q    = sign_dvd ^ sign_dvs;
    assign q_ovf    = neg_q ? (dvd_q > NEG_LIMIT) : (|dvd_q[DIVIDEND_W-1:QUOT_W-1]);
    assign q_lo     = dvd_q[QUOT_W-1:0];
    assign q_signed = neg_q ? -q_lo : q_lo;
    assign r_signed = sign_dvd ? -rem[DIVISOR_W-1:0] : rem[DIVISOR_W-1:0];
    assign q_sat    = (zero_div ? sign_dvd : neg_q) ? QUOT_MIN : QUOT_MAX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            dvd_q       <= '0;
            rem         <= '0;
            dvs         <= '0;
            sign_dvd    <= 1'b0;
            sign_dvs    <= 1'b0;
            zero_div    <= 1'b0;
            fin_wait    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sign_dvd <= dividend[DIVIDEND_W-1];
                        sign_dvs <= divisor[DIVISOR_W-1];
                        dvs      <= divisor_abs;
                        rem      <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        if (divisor == '0) begin
                            // Raw dividend kept so its low half becomes the remainder.
                            zero_div <= 1'b1;
                            fin_wait <= 1'b1;
                            dvd_q    <= dividend;
                            state    <= FIN;
                        end else begin
                            zero_div <= 1'b0;
                            fin_wait <= 1'b0;
                            dvd_q    <= dividend_abs;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    dvd_q <= {dvd_q[DIVIDEND_W-2:0], q_bit};
                    rem   <= rem_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == {ITER_CNT_W{1'b1}}) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    if (fin_wait) begin
                        fin_wait <= 1'b0;
                    end else begin
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                        div_by_zero <= zero_div;
                        if (zero_div) begin
                            overflow  <= 1'b0;
                            quotient  <= q_sat;
                            remainder <= dvd_q[DIVISOR_W-1:0];
                        end else begin
                            overflow  <= q_ovf;
                            quotient  <= q_ovf ? q_sat : q_signed;
                            remainder <= r_signed;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_256.sv
// Directed bench for seq_divider_256: arithmetic reference model plus literal expectations.
module tb_seq_divider_256;

    localparam logic [127:0] Q_MAX = {1'b0, {127{1'b1}}};
    localparam logic [127:0] Q_MIN = {1'b1, {127{1'b0}}};

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [255:0] dividend;
    logic [127:0] divisor;
    logic         busy;
    logic         done;
    logic [127:0] quotient;
    logic [127:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    seq_divider_256 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int done_count = 0;

    logic [127:0] lit_q, lit_r;
    logic         lit_dz, lit_ov;
    int           lit_lat;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Reference: exact wide signed arithmetic, then saturation rules.
    task automatic model(input logic [255:0] a_in, input logic [127:0] b_in,
                         output logic [127:0] q, output logic [127:0] r,
                         output logic dz, output logic ov);
        logic signed [257:0] a, b, qq, rr, lim_hi, lim_lo;
        a = {{2{a_in[255]}}, a_in};
        b = {{130{b_in[127]}}, b_in};
        lim_hi = (258'sd1 <<< 127) - 258'sd1;
        lim_lo = -(258'sd1 <<< 127);
        if (b == 0) begin
            dz = 1'b1;
            ov = 1'b0;
            q  = a_in[255] ? Q_MIN : Q_MAX;
            r  = a_in[127:0];
        end else begin
            qq = a / b;
            rr = a % b;
            dz = 1'b0;
            ov = (qq > lim_hi) || (qq < lim_lo);
            q  = ov ? ((qq > 0) ? Q_MAX : Q_MIN) : qq[127:0];
            r  = rr[127:0];
        end
    endtask

    // Single compare process: tracks expected busy/done timing and checks every cycle.
    logic         armed = 1'b0;
    int           cyc, exp_lat, l_lat;
    logic [127:0] e_q, e_r, l_q, l_r;
    logic         e_dz, e_ov, l_dz, l_ov;
    logic [127:0] h_q = '0, h_r = '0;
    logic         h_dz = 1'b0, h_ov = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            armed = 1'b0;
            h_q = '0; h_r = '0; h_dz = 1'b0; h_ov = 1'b0;
        end else if (start && !armed) begin
            model(dividend, divisor, e_q, e_r, e_dz, e_ov);
            exp_lat = e_dz ? 2 : 257;
            l_q = lit_q; l_r = lit_r; l_dz = lit_dz; l_ov = lit_ov; l_lat = lit_lat;
            cyc = -1;
            armed = 1'b1;
        end
        #1;
        if (!rst_n) begin
            chk("rst_busy", 128'(busy), 128'(0));
            chk("rst_done", 128'(done), 128'(0));
            chk("rst_q", quotient, '0);
            chk("rst_r", remainder, '0);
            chk("rst_dz", 128'(div_by_zero), 128'(0));
            chk("rst_ov", 128'(overflow), 128'(0));
        end else if (armed && (cyc + 1 == exp_lat)) begin
            cyc++;
            chk("busy_at_done", 128'(busy), 128'(0));
            chk("done", 128'(done), 128'(1));
            chk("lit_latency", 128'(cyc), 128'(l_lat));
            chk("q_model", quotient, e_q);
            chk("r_model", remainder, e_r);
            chk("dz_model", 128'(div_by_zero), 128'(e_dz));
            chk("ov_model", 128'(overflow), 128'(e_ov));
            chk("q_lit", quotient, l_q);
            chk("r_lit", remainder, l_r);
            chk("dz_lit", 128'(div_by_zero), 128'(l_dz));
            chk("ov_lit", 128'(overflow), 128'(l_ov));
            h_q = e_q; h_r = e_r; h_dz = e_dz; h_ov = e_ov;
            armed = 1'b0;
            done_count++;
        end else begin
            if (armed) cyc++;
            chk("busy", 128'(busy), 128'(armed));
            chk("done_early", 128'(done), 128'(0));
            chk("q_held", quotient, h_q);
            chk("r_held", remainder, h_r);
            chk("dz_held", 128'(div_by_zero), 128'(h_dz));
            chk("ov_held", 128'(overflow), 128'(h_ov));
        end
    end

    // Called at a negedge; returns at the negedge inside the done cycle so the next call is back-to-back.
    task automatic run_op(input logic [255:0] a, input logic [127:0] b,
                          input logic [127:0] lq, input logic [127:0] lr,
                          input logic ldz, input logic lov, input int llat, input int glitch);
        int n0;
        n0 = done_count;
        lit_q = lq; lit_r = lr; lit_dz = ldz; lit_ov = lov; lit_lat = llat;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_count != n0) break;
            start = (i == glitch);
            if (i == glitch) begin
                dividend = ~a;
                divisor  = b + 128'd1;
            end
        end
        start = 1'b0;
    endtask

    logic [255:0] prod;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        lit_q = '0; lit_r = '0; lit_dz = 1'b0; lit_ov = 1'b0; lit_lat = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op(256'd100, 128'd7, 128'd14, 128'd2, 1'b0, 1'b0, 257, -1);
        run_op(-256'sd100, 128'd7, -128'sd14, -128'sd2, 1'b0, 1'b0, 257, -1);
        run_op(256'd100, -128'sd7, -128'sd14, 128'd2, 1'b0, 1'b0, 257, -1);
        run_op(-256'sd100, -128'sd7, 128'd14, -128'sd2, 1'b0, 1'b0, 257, -1);

        prod = ((256'd1 << 100) + 256'd3) * (-((256'd1 << 90) + 256'd5));
        run_op(prod, -((128'd1 << 90) + 128'd5), (128'd1 << 100) + 128'd3, 128'd0, 1'b0, 1'b0, 257, -1);

        run_op(256'd5, 128'd0, Q_MAX, 128'd5, 1'b1, 1'b0, 2, -1);
        run_op(-256'sd5, 128'd0, Q_MIN, -128'sd5, 1'b1, 1'b0, 2, -1);

        run_op(256'd1 << 200, 128'd1, Q_MAX, 128'd0, 1'b0, 1'b1, 257, -1);
        run_op(-(256'd1 << 127), 128'd1, Q_MIN, 128'd0, 1'b0, 1'b0, 257, -1);
        run_op(256'd1 << 255, {128{1'b1}}, Q_MAX, 128'd0, 1'b0, 1'b1, 257, -1);
        run_op(-(256'd1 << 127), {128{1'b1}}, Q_MAX, 128'd0, 1'b0, 1'b1, 257, -1);
        run_op(256'd1 << 130, Q_MIN, -128'sd8, 128'd0, 1'b0, 1'b0, 257, -1);
        run_op(256'd7, 128'd100, 128'd0, 128'd7, 1'b0, 1'b0, 257, -1);

        // start pulsed mid-flight with other operands must not disturb the result
        run_op(256'd100, 128'd7, 128'd14, 128'd2, 1'b0, 1'b0, 257, 49);

        // abort by reset: start, ignored start near cycle 50, reset near cycle 100
        dividend = 256'd1000;
        divisor  = 128'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (48) @(negedge clk);
        start = 1'b1;
        dividend = 256'd77;
        divisor  = 128'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_op(256'd9, 128'd3, 128'd3, 128'd0, 1'b0, 1'b0, 257, -1);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
